// File: rtl/oled_cmd_seq.sv
// SSD1306 byte sequencer: RES pulse, 25-byte init list, then client bytes (`OLED_CLEAR_ON_INIT_EN adds a GDDRAM wipe).
// Latency: one byte per 17 cycles (16 cycles WRITE_EN high + 1 gap); client byte loads on the accepting edge.
// Backpressure: IN_READY only in IDLE or in a post-init GAP; an unaccepted IN_VALID just waits.
module oled_cmd_seq #(
  parameter int RES_LOW_CYCLES  = 2500,
  parameter int RES_WAIT_CYCLES = 2500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SPI_WRITE_DONE,
  output logic       SPI_WRITE_EN,
  output logic [7:0] SPI_DATA,
  output logic       OLED_DC,
  output logic       OLED_RES,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       IN_DC,
  output logic       IN_READY,
  output logic       INIT_DONE,
  output logic       BUSY
);

  localparam int CNT_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(RES_LOW_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RES_WAIT_CYCLES - 1);
  localparam logic [4:0]    INIT_LAST = 5'd24;

  typedef enum logic [2:0] {
    S_RES_LOW,
    S_RES_WAIT,
    S_SEND,
    S_GAP,
`ifdef OLED_CLEAR_ON_INIT_EN
    S_CLEAR,
`endif
    S_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    init_idx;
`ifdef OLED_CLEAR_ON_INIT_EN
  logic [10:0]   clr_cnt;
`endif
  logic          accept;

  assign accept = IN_VALID && IN_READY;

  // 20 00 selects horizontal addressing so a linear stream fills the panel.
  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'hCF;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      5'd24:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_RES_LOW;
      cnt          <= '0;
      init_idx     <= '0;
`ifdef OLED_CLEAR_ON_INIT_EN
      clr_cnt      <= '0;
`endif
      SPI_WRITE_EN <= 1'b0;
      SPI_DATA     <= 8'h00;
      OLED_DC      <= 1'b0;
      OLED_RES     <= 1'b0;
      IN_READY     <= 1'b0;
      INIT_DONE    <= 1'b0;
      BUSY         <= 1'b1;
    end else begin
      case (state)
        S_RES_LOW: begin
          if (cnt == LOW_LAST) begin
            cnt      <= '0;
            OLED_RES <= 1'b1;
            state    <= S_RES_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RES_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt          <= '0;
            init_idx     <= '0;
            SPI_DATA     <= init_byte(5'd0);
            OLED_DC      <= 1'b0;
            SPI_WRITE_EN <= 1'b1;
            state        <= S_SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef OLED_CLEAR_ON_INIT_EN
        S_SEND, S_CLEAR: begin
`else
        S_SEND: begin
`endif
          // DATA/DC stay frozen; the writer samples them for the whole window.
          if (SPI_WRITE_DONE) begin
            SPI_WRITE_EN <= 1'b0;
            IN_READY     <= INIT_DONE;
            state        <= S_GAP;
          end
        end

        S_GAP: begin
          if (!INIT_DONE) begin
            if (init_idx != INIT_LAST) begin
              init_idx     <= init_idx + 5'd1;
              SPI_DATA     <= init_byte(init_idx + 5'd1);
              OLED_DC      <= 1'b0;
              SPI_WRITE_EN <= 1'b1;
              state        <= S_SEND;
            end
`ifdef OLED_CLEAR_ON_INIT_EN
            else if (clr_cnt != 11'd1024) begin
              clr_cnt      <= clr_cnt + 11'd1;
              SPI_DATA     <= 8'h00;
              OLED_DC      <= 1'b1;
              SPI_WRITE_EN <= 1'b1;
              state        <= S_CLEAR;
            end
`endif
            else begin
              INIT_DONE <= 1'b1;
              IN_READY  <= 1'b1;
              BUSY      <= 1'b0;
              state     <= S_IDLE;
            end
          end else if (accept) begin
            SPI_DATA     <= IN_DATA;
            OLED_DC      <= IN_DC;
            SPI_WRITE_EN <= 1'b1;
            IN_READY     <= 1'b0;
            state        <= S_SEND;
          end else begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (accept) begin
            SPI_DATA     <= IN_DATA;
            OLED_DC      <= IN_DC;
            SPI_WRITE_EN <= 1'b1;
            IN_READY     <= 1'b0;
            BUSY         <= 1'b1;
            state        <= S_SEND;
          end
        end

        default: state <= S_RES_LOW;
      endcase
    end
  end

endmodule

// File: doc/oled_cmd_seq.md
Name: oled_cmd_seq

Overview:
- Byte sequencer directly upstream of the SPI byte writer. It drives that writer's WRITE_EN and DATA_IN, and consumes its WRITE_DONE.
- After reset it performs the SSD1306 power-up sequence: hardware reset pulse on RES, then a fixed 25-byte init command list.
- After init it streams bytes from a valid/ready client. Each byte carries its own D/C flag.
- Target clock is CLK = 25 MHz.

Parameters:
- RES_LOW_CYCLES, 2500: cycles OLED_RES is held low after reset (100 us).
- RES_WAIT_CYCLES, 2500: cycles after OLED_RES rises before the first SPI byte.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- SPI_WRITE_DONE  in  1  WRITE_DONE from the SPI byte writer
- SPI_WRITE_EN  out  1  WRITE_EN to the SPI byte writer
- SPI_DATA  out  8  DATA_IN to the SPI byte writer
- OLED_DC  out  1  display D/C pin; 0 = command, 1 = data
- OLED_RES  out  1  display reset pin, active-low
- IN_VALID  in  1  client byte valid
- IN_DATA  in  8  client byte
- IN_DC  in  1  client D/C flag
- IN_READY  out  1  sequencer can accept a client byte
- INIT_DONE  out  1  init complete; sticky until RST
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: CLK with RST=1 forces the following. Values hold while RST=1.
  - State RES_LOW, counters cleared.
  - SPI_WRITE_EN=0, SPI_DATA=0, OLED_DC=0, OLED_RES=0.
  - IN_READY=0, INIT_DONE=0, BUSY=1.
- Mid-byte reset: SPI_WRITE_EN drops on the next edge, so the writer aborts and raises CS.
- All outputs are registered.
- States: RES_LOW -> RES_WAIT -> SEND -> GAP -> (SEND ...) -> IDLE.
- RES_LOW:
  - OLED_RES=0 for exactly RES_LOW_CYCLES cycles, then OLED_RES=1 and go to RES_WAIT.
- RES_WAIT:
  - Count RES_WAIT_CYCLES cycles, then load init byte 0 and enter SEND.
- Init ROM: 25 bytes, all sent with OLED_DC=0, in this order:
  - AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF
  - 20 00 selects horizontal addressing.
- SEND:
  - SPI_WRITE_EN=1. SPI_DATA and OLED_DC are stable for the whole state.
  - The writer samples DATA_IN throughout, so neither may change here.
  - At the edge where SPI_WRITE_DONE=1 is sampled, SPI_WRITE_EN<=0 and go to GAP.
  - Result: SPI_WRITE_EN is high for exactly 16 cycles per byte. The writer's 16th cycle produces the final SCLK rise.
  - SPI_WRITE_DONE seen outside SEND is ignored.
- GAP (exactly 1 cycle, SPI_WRITE_EN=0): lets the writer return to idle and CS go high. Exit depends on phase:
  - Init bytes left: load the next byte, go to SEND.
  - Last init byte just sent: INIT_DONE<=1, go to IDLE, or to CLEAR when that feature is enabled.
  - Streaming: if IN_VALID && IN_READY, accept and go to SEND; otherwise go to IDLE.
- IDLE: IN_READY=1 and BUSY=0.
- Client handshake:
  - IN_READY=1 only in IDLE, and in GAP once INIT_DONE=1.
  - A byte is accepted on a clock edge with IN_VALID && IN_READY. That same edge loads SPI_DATA<=IN_DATA, OLED_DC<=IN_DC, SPI_WRITE_EN<=1, IN_READY<=0.
  - IN_VALID while IN_READY=0 is ignored; the client holds IN_DATA/IN_DC until accepted.
  - Back-to-back throughput: one byte per 17 cycles.
- Init duration: RES_LOW_CYCLES + RES_WAIT_CYCLES + 25*17 cycles from RST release to INIT_DONE.
- Counter widths: $clog2 of the larger parameter + 1. The init index is 5 bits and never wraps past 24.

Optional Feature:
- Macro: OLED_CLEAR_ON_INIT_EN.
- Defined:
  - After the last init byte's GAP, enter CLEAR and send 1024 bytes of 0x00 with OLED_DC=1. This blanks 128x64 GDDRAM.
  - Each byte uses the same SEND/GAP timing.
  - INIT_DONE rises at the GAP after byte 1024. Total added time: 1024*17 cycles.
  - IN_READY stays 0 throughout CLEAR.
  - Clear counter: 11 bits.
- Undefined: the CLEAR state and its counter are absent, and INIT_DONE rises after the init list.

Test Plan:
- Parameters for all scenarios: RES_LOW_CYCLES=4, RES_WAIT_CYCLES=3, writer-model bench.
1. Release RST -> OLED_RES=0 for exactly 4 cycles, then 3 idle cycles, then SPI_WRITE_EN high with SPI_DATA=0xAE, OLED_DC=0.
2. Run init with the writer model (WRITE_DONE after 15 EN-high edges) -> captured sequence equals the 25-byte list, each EN window is 16 cycles with a 1-cycle gap, and INIT_DONE=1 at cycle 4+3+425.
3. After INIT_DONE, hold IN_VALID=1 and present 0x55/DC=1 then 0xA5/DC=0 -> both bytes are sent, EN windows are 17 cycles apart, OLED_DC is 1 then 0, and IN_READY pulses only in GAP.
4. Assert IN_VALID during init -> not accepted and IN_READY=0. The byte is accepted on the first IDLE cycle after INIT_DONE.
5. Assert RST for 1 cycle during the 8th EN cycle of a client byte -> next edge shows SPI_WRITE_EN=0, OLED_RES=0, INIT_DONE=0, and the sequence restarts from scenario 1.
6. With OLED_CLEAR_ON_INIT_EN defined -> after 0xAF, 1024 bytes of 0x00 are sent with DC=1, and INIT_DONE rises after the last of them.
